// File: rtl/rgb_axis_packer_pkg.sv
// Shared types for the RGB-to-AXI-Stream packer: FSM states, widths and the buffered beat layout.
package generic_pack;

  localparam int AXIS_DATA_W = 32;
  localparam int PIXEL_W     = 8;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    STREAM   = 2'd1,
    DROP     = 2'd2
  } packer_state_t;

  typedef struct packed {
    logic                   tuser;
    logic                   tlast;
    logic [AXIS_DATA_W-1:0] tdata;
  } axis_beat_t;

  localparam int BEAT_W = $bits(axis_beat_t);

endpackage

// File: rtl/rgb_axis_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous reset.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module rgb_axis_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_fire, rd_fire;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_fire = rd_en && !empty;
  // A write into a full FIFO lands in the slot being popped on the same edge.
  assign wr_fire = wr_en && (!full || rd_fire);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, wr_fire};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, rd_fire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rgb_axis_packer.sv
// Packs a qualified RGB pixel stream into 32-bit AXI-Stream beats through an FWFT buffer.
// Define RGB_AXIS_PACKER_STATS_EN to build the pixel/drop statistics counters.
//
// state    | meaning
// WAIT_SOF | after reset; discard pixels until the first start-of-frame
// STREAM   | write every pixel into the buffer
// DROP     | buffer overflowed; discard pixels until a start-of-frame fits
module rgb_axis_packer
  import generic_pack::*;
#(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] ALPHA_VALUE = 8'h00
) (
  input  logic                   pixclk,
  input  logic                   reset,
  input  logic                   valid,
  input  logic                   iSof,
  input  logic                   iEol,
  input  logic [PIXEL_W-1:0]     iRed,
  input  logic [PIXEL_W-1:0]     iGreen,
  input  logic [PIXEL_W-1:0]     iBlue,
  input  logic                   m_axis_mm2s_tready,
  output logic                   m_axis_mm2s_tvalid,
  output logic [AXIS_DATA_W-1:0] m_axis_mm2s_tdata,
  output logic                   m_axis_mm2s_tuser,
  output logic                   m_axis_mm2s_tlast,
  output logic                   overflow,
  output logic [31:0]            pixel_count,
  output logic [15:0]            drop_count
);

  packer_state_t state_q, state_d;
  logic          overflow_q, overflow_d;
  logic          wr_en, drop, pop, full, empty;
  axis_beat_t    wr_beat, head;

  assign wr_beat.tuser = iSof;
  assign wr_beat.tlast = iEol;
  assign wr_beat.tdata = {ALPHA_VALUE, iRed, iGreen, iBlue};
  assign pop           = !empty && m_axis_mm2s_tready;

  rgb_axis_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_W)
  ) u_fifo (
    .clk     (pixclk),
    .rst     (reset),
    .wr_en   (wr_en),
    .wr_data (wr_beat),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    drop       = 1'b0;
    if (valid) begin
      unique case (state_q)
        WAIT_SOF: begin
          if (iSof) begin
            wr_en   = 1'b1;
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (!full || pop) begin
            wr_en = 1'b1;
          end else begin
            drop       = 1'b1;
            overflow_d = 1'b1;
            state_d    = DROP;
          end
        end
        DROP: begin
          if (iSof && !full) begin
            wr_en   = 1'b1;
            state_d = STREAM;
          end else begin
            drop = 1'b1;
          end
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_q    <= WAIT_SOF;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // Buffer RAM is not reset, so the data outputs are forced to zero while empty.
  assign m_axis_mm2s_tvalid = !empty;
  assign m_axis_mm2s_tdata  = empty ? '0   : head.tdata;
  assign m_axis_mm2s_tuser  = empty ? 1'b0 : head.tuser;
  assign m_axis_mm2s_tlast  = empty ? 1'b0 : head.tlast;
  assign overflow           = overflow_q;

`ifdef RGB_AXIS_PACKER_STATS_EN
  logic [31:0] pixel_count_q, pixel_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    pixel_count_d = pixel_count_q + {31'd0, wr_en};
    drop_count_d  = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      pixel_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      pixel_count_q <= pixel_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign pixel_count = pixel_count_q;
  assign drop_count  = drop_count_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign pixel_count = '0;
  assign drop_count  = '0;
`endif

endmodule

// File: doc/rgb_axis_packer.md
RGB_AXIS_PACKER -- requirements
Module: rgb_axis_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, buffer entries; power of two, minimum 4.
REQ-002 Parameter ALPHA_VALUE, default 8'h00, constant placed in tdata[31:24].
REQ-003 pixclk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 valid  in  1  pixel qualifier; one pixel per cycle when high.
REQ-006 iSof  in  1  first pixel of frame; qualified by valid.
REQ-007 iEol  in  1  last pixel of line; qualified by valid.
REQ-008 iRed, iGreen, iBlue  in  8 each  pixel components.
REQ-009 m_axis_mm2s_tready  in  1  downstream ready.
REQ-010 m_axis_mm2s_tvalid  out  1  beat valid.
REQ-011 m_axis_mm2s_tdata  out  32  {ALPHA_VALUE, R, G, B}.
REQ-012 m_axis_mm2s_tuser  out  1  beat carries iSof.
REQ-013 m_axis_mm2s_tlast  out  1  beat carries iEol.
REQ-014 overflow  out  1  sticky pixel-loss flag.
REQ-015 pixel_count  out  32; drop_count  out  16  statistics (REQ-032).

Function
REQ-016 Each FIFO entry SHALL hold 34 bits: {tuser, tlast, tdata}.
REQ-017 Handshake: a beat transfers on tvalid && tready; while tvalid && !tready, tdata/tuser/tlast SHALL hold stable.
REQ-018 tvalid SHALL be high whenever the FIFO is non-empty; first-word fall-through.
REQ-019 Latency: a pixel written into an empty FIFO at edge N SHALL appear on tvalid after edge N (1 cycle).
REQ-020 States: WAIT_SOF, STREAM, DROP.
- Reset state: WAIT_SOF.
REQ-021 WAIT_SOF: valid && !iSof pixels discarded, not counted as drops.
- valid && iSof: pixel written, go to STREAM.
REQ-022 STREAM: valid pixels written while not full; iSof in STREAM is written, state unchanged.
REQ-023 Full-FIFO write in STREAM:
- Pop on the same cycle (tvalid && tready): write accepted, no overflow.
- Otherwise: pixel discarded, overflow set, go to DROP.
REQ-024 DROP: all valid pixels discarded and counted.
- valid && iSof with FIFO not full: that pixel written, go to STREAM.
- iSof with FIFO full: pixel discarded, stay in DROP.
REQ-025 Empty FIFO: a pop is impossible; a simultaneous write goes to the FIFO, not directly to the output.
REQ-026 Read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full/empty from the MSB comparison.
REQ-027 overflow SHALL stay high until reset.

Reset
REQ-028 On reset, outputs SHALL be 0 from the next edge: tvalid, tdata, tuser, tlast, overflow, pixel_count, drop_count.
REQ-029 Reset SHALL clear both pointers and return to WAIT_SOF.
REQ-030 Reset mid-frame SHALL discard buffered beats without emitting them; valid is ignored during reset.

Configuration
REQ-031 Macro RGB_AXIS_PACKER_STATS_EN.
REQ-032 Defined:
- pixel_count increments on each FIFO write, wrapping at 2^32.
- drop_count increments on each discarded pixel in DROP or on a full FIFO, saturating at 16'hFFFF.
- Neither counter counts WAIT_SOF discards.
REQ-033 Undefined: pixel_count and drop_count SHALL be tied to 0 with no counter logic; ports remain present.

Structure
REQ-034 Package generic_pack SHALL hold:
- the state enum packer_state_t;
- constants AXIS_DATA_W = 32 and PIXEL_W = 8;
- the {tuser, tlast, tdata} struct type.
REQ-035 Sub-module rgb_axis_fifo: synchronous FWFT FIFO with single clock and synchronous reset, parameterised by depth and width.

Verification
REQ-036 Reset, then valid with iSof=1, RGB=12/34/56, tready=1 -> next cycle tvalid=1, tdata=32'h00123456, tuser=1.
REQ-037 tready=0, 16 pixels after SOF, then one more pixel -> overflow=1 (sticky), drop_count=1, state DROP; tready=1 drains exactly 16 beats.
REQ-038 FIFO full, tready=1, valid pixel on the same cycle -> write accepted, overflow stays 0.
REQ-039 Pixels without prior iSof after reset -> no beats, drop_count=0; then iSof -> first beat has tuser=1.
REQ-040 Line of 640 pixels, iEol on the last, tready toggling 50% -> 640 beats, tlast only on beat 640, data in order.
REQ-041 Reset asserted with 5 beats buffered -> tvalid=0 next cycle, no stale beat after release; without STATS_EN, counters read 0 throughout.
